// File: rtl/bus_decoder_ctrl_pkg.sv
// rtl/bus_decoder_ctrl_pkg.sv - shared states, default address map and width helper
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_e;

  localparam int BUS_ADDR_W      = 8;
  localparam int BUS_DATA_W      = 8;
  localparam int BUS_NUM_SLAVES  = 4;
  localparam int BUS_REGION_BITS = 5;
  localparam int BUS_BASE_ADDR   = 0;
  localparam int BUS_TIMEOUT     = 16;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_decoder_ctrl_if.sv
// rtl/bus_decoder_ctrl_if.sv - master-side and slave-side bus signals of the decoder
interface bus_decoder_ctrl_if
  import bus_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int NUM_SLAVES = BUS_NUM_SLAVES
);
  logic                         m_req;
  logic                         m_wr;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_ack;
  logic                         m_err;
  logic [NUM_SLAVES-1:0]        s_sel;
  logic                         s_wr;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_ack;

  modport slave (
    input  m_req, m_wr, m_addr, m_wdata, s_rdata, s_ack,
    output m_rdata, m_ack, m_err, s_sel, s_wr, s_addr, s_wdata
  );

  modport master (
    output m_req, m_wr, m_addr, m_wdata, s_rdata, s_ack,
    input  m_rdata, m_ack, m_err, s_sel, s_wr, s_addr, s_wdata
  );
endinterface

// File: rtl/bus_decoder_ctrl_region_dec.sv
// rtl/bus_decoder_ctrl_region_dec.sv - combinational address to region hit/index/one-hot decode
module bus_region_dec
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int NUM_SLAVES  = BUS_NUM_SLAVES,
  parameter int REGION_BITS = BUS_REGION_BITS,
  parameter int BASE_ADDR   = BUS_BASE_ADDR,
  localparam int IDX_W      = min1_clog2(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] onehot
);
  logic [ADDR_W-1:0] off;
  logic [31:0]       region;

  // Offset-based compare: the region index never wraps past the top of the address space.
  assign off    = addr - ADDR_W'(BASE_ADDR);
  assign region = 32'(off >> REGION_BITS);
  assign hit    = (addr >= ADDR_W'(BASE_ADDR)) && (region < 32'(NUM_SLAVES));
  assign idx    = region[IDX_W-1:0];
  assign onehot = hit ? (NUM_SLAVES'(1) << idx) : '0;
endmodule

// File: rtl/bus_decoder_ctrl.sv
// rtl/bus_decoder_ctrl.sv - registered address decoder and single-transaction bus controller
module bus_decoder_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int NUM_SLAVES  = BUS_NUM_SLAVES,
  parameter int REGION_BITS = BUS_REGION_BITS,
  parameter int BASE_ADDR   = BUS_BASE_ADDR,
  parameter int TIMEOUT     = BUS_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  bus_decoder_ctrl_if.slave   bus,
  output logic                busy,
  output logic [7:0]          err_count
);
  localparam int IDX_W = min1_clog2(NUM_SLAVES);
  localparam int CNT_W = min1_clog2(TIMEOUT);

  bus_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;

  bus_region_dec #(
    .ADDR_W      (ADDR_W),
    .NUM_SLAVES  (NUM_SLAVES),
    .REGION_BITS (REGION_BITS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_dec (
    .addr   (bus.m_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          wr_d    = bus.m_wr;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          cnt_d   = '0;
          if (dec_hit) begin
            sel_d   = dec_onehot;
            idx_d   = dec_idx;
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            sel_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Only the selected slave's ack counts, and it beats a coincident timeout.
        if (bus.s_ack[idx_q]) begin
          if (!wr_q) rdata_d = bus.s_rdata[idx_q*DATA_W +: DATA_W];
          sel_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          sel_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.s_sel   = sel_q;
  assign bus.s_wr    = wr_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.m_rdata = rdata_q;
  assign bus.m_ack   = (state_q == RESP) && !err_q;
  assign bus.m_err   = (state_q == RESP) && err_q;
  assign busy        = (state_q != IDLE);
  assign err_count   = err_count_q;
endmodule
